// File: rtl/cache_mgmt_unit.sv
// Cache controller between the MEM stage, a 2-way set-associative cache array and a word-wide memory port.
// Stalls the CPU on a miss, writes back a dirty victim, refills the line, then replays the access.
module cache_mgmt_unit #(
    parameter int ADDR_BITS  = 32,
    parameter int TAG_BITS   = 23,
    parameter int INDEX_BITS = 5,
    parameter int LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [ADDR_BITS-1:0] addr_rw,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, BACK_RD, BACK_WR, FILL, WAIT} state_t;

    state_t                state, state_nxt;
    logic [WORD_BITS-1:0]  word, word_nxt;
    logic [TAG_BITS-1:0]   victim_tag, victim_tag_nxt;
    logic [31:0]           wb_buf;
    logic                  wb_fresh;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [ADDR_BITS-1:0]  victim_addr, fill_addr;
    logic [31:0]           wb_data;

    logic [ADDR_BITS-1:0]  addr_c, maddr_c;
    logic [31:0]           din_c, rdata_c, mdata_c;
    logic [2:0]            ubhw_c;
    logic                  load_c, edit_c, store_c, stall_c, cs_c, we_c;

    assign index       = addr_rw[WORD_BITS+2 +: INDEX_BITS];
    assign req_tag     = addr_rw[ADDR_BITS-1 -: TAG_BITS];
    assign victim_addr = {victim_tag, index, word, 2'b00};
    assign fill_addr   = {req_tag, index, word, 2'b00};
    // The victim word arrives one cycle after BACK_RD; forward it until the buffer holds it.
    assign wb_data     = wb_fresh ? cache_dout : wb_buf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            word       <= '0;
            victim_tag <= '0;
            wb_buf     <= '0;
            wb_fresh   <= 1'b0;
        end else begin
            state      <= state_nxt;
            word       <= word_nxt;
            victim_tag <= victim_tag_nxt;
            wb_fresh   <= (state == BACK_RD);
            if (wb_fresh) begin
                wb_buf <= cache_dout;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        word_nxt       = word;
        victim_tag_nxt = victim_tag;
        addr_c         = addr_rw;
        din_c          = data_w;
        ubhw_c         = u_b_h_w;
        rdata_c        = '0;
        load_c         = 1'b0;
        edit_c         = 1'b0;
        store_c        = 1'b0;
        stall_c        = 1'b1;
        cs_c           = 1'b0;
        we_c           = 1'b0;
        maddr_c        = '0;
        mdata_c        = '0;
        case (state)
            IDLE: begin
                if (en_w) begin
                    edit_c = 1'b1;
                end else if (en_r) begin
                    load_c = 1'b1;
                end
                if (en_r || en_w) begin
                    state_nxt = LOOKUP;
                end else begin
                    stall_c = 1'b0;
                end
            end
            LOOKUP: begin
                if (cache_hit) begin
                    stall_c   = 1'b0;
                    rdata_c   = cache_dout;
                    state_nxt = IDLE;
                end else begin
                    victim_tag_nxt = cache_tag;
                    word_nxt       = '0;
                    state_nxt      = (cache_valid && cache_dirty) ? BACK_RD : FILL;
                end
            end
            BACK_RD: begin
                addr_c    = victim_addr;
                state_nxt = BACK_WR;
            end
            BACK_WR: begin
                // Keep the victim address on the cache so its read data stays put while memory is slow.
                addr_c  = victim_addr;
                cs_c    = 1'b1;
                we_c    = 1'b1;
                maddr_c = victim_addr;
                mdata_c = wb_data;
                if (mem_ack_i) begin
                    if (word == LAST_WORD) begin
                        word_nxt  = '0;
                        state_nxt = FILL;
                    end else begin
                        word_nxt  = word + 1'b1;
                        state_nxt = BACK_RD;
                    end
                end
            end
            FILL: begin
                cs_c    = 1'b1;
                maddr_c = fill_addr;
                if (mem_ack_i) begin
                    store_c = 1'b1;
                    addr_c  = fill_addr;
                    din_c   = mem_data_i;
                    ubhw_c  = 3'b010;
                    if (word == LAST_WORD) begin
                        word_nxt  = '0;
                        state_nxt = WAIT;
                    end else begin
                        word_nxt = word + 1'b1;
                    end
                end
            end
            WAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is held, independent of the registered state.
    assign data_r        = rst ? rdata_c : '0;
    assign stall         = rst ? stall_c : 1'b0;
    assign cache_addr    = rst ? addr_c  : '0;
    assign cache_load    = rst ? load_c  : 1'b0;
    assign cache_edit    = rst ? edit_c  : 1'b0;
    assign cache_store   = rst ? store_c : 1'b0;
    assign cache_u_b_h_w = rst ? ubhw_c  : 3'b000;
    assign cache_din     = rst ? din_c   : '0;
    assign mem_cs_o      = rst ? cs_c    : 1'b0;
    assign mem_we_o      = rst ? we_c    : 1'b0;
    assign mem_addr_o    = rst ? maddr_c : '0;
    assign mem_data_o    = rst ? mdata_c : '0;

endmodule

// File: tb/tb_cache_mgmt_unit.sv
// Directed bench for cache_mgmt_unit with a small cache array model and a memory responder
// whose ack latency is adjustable per scenario.
module tb_cache_mgmt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_r, en_w;
    logic [2:0]  u_b_h_w;
    logic [31:0] addr_rw, data_w, data_r;
    logic        stall;
    logic [31:0] cache_addr, cache_din, cache_dout;
    logic        cache_load, cache_edit, cache_store;
    logic [2:0]  cache_u_b_h_w;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [22:0] cache_tag;
    logic        mem_cs_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

    int checks = 0;
    int errors = 0;

    logic hit_force = 1'b0;
    int   st_goal   = 1000;
    int   ack_delay = 0;
    int   wait_cnt  = 0;

    logic [31:0] rd_log [64];
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    logic [31:0] st_addr_log [64];
    logic [31:0] st_din_log [64];
    logic [2:0]  st_w_log [64];
    int rd_n = 0, wr_n = 0, st_n = 0, edit_n = 0, load_n = 0, unstable_n = 0;
    logic        pend = 1'b0;
    logic        p_we;
    logic [31:0] p_addr, p_data;

    logic [31:0] cache_mem [logic [31:0]];

    int          stalls, rb, wb, sb, eb, lb, ub;
    logic [31:0] rdata, iaddr, idin;
    logic [1:0]  istr;
    logic        found;

    cache_mgmt_unit dut (
        .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .u_b_h_w(u_b_h_w),
        .addr_rw(addr_rw), .data_w(data_w), .data_r(data_r), .stall(stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
        .cache_store(cache_store), .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
        .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag), .cache_dout(cache_dout),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    // The line reads as a hit once the scenario's four refill words have been stored.
    assign cache_hit = hit_force | (st_n >= st_goal);

    // Registered cache array: unwritten words read back as 0xD000_0000 | address.
    always @(posedge clk) begin
        cache_dout <= cache_mem.exists(cache_addr) ? cache_mem[cache_addr] : (32'hD000_0000 | cache_addr);
        if (cache_store) cache_mem[cache_addr] = cache_din;
    end

    // Memory answers each word after ack_delay waiting cycles with 0xA500_0000 | address.
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (mem_cs_o) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack_i  = 1'b1;
                mem_data_i = 32'hA500_0000 | mem_addr_o;
                wait_cnt   = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (cache_edit) edit_n++;
        if (cache_load) load_n++;
        if (cache_store && st_n < 64) begin
            st_addr_log[st_n] = cache_addr;
            st_din_log[st_n]  = cache_din;
            st_w_log[st_n]    = cache_u_b_h_w;
            st_n++;
        end
        if (mem_cs_o && mem_ack_i) begin
            if (mem_we_o && wr_n < 64) begin
                wr_addr_log[wr_n] = mem_addr_o;
                wr_data_log[wr_n] = mem_data_o;
                wr_n++;
            end else if (!mem_we_o && rd_n < 64) begin
                rd_log[rd_n] = mem_addr_o;
                rd_n++;
            end
        end
        if (mem_cs_o && pend && (mem_addr_o !== p_addr || mem_data_o !== p_data || mem_we_o !== p_we))
            unstable_n++;
        pend   = mem_cs_o && !mem_ack_i;
        p_addr = mem_addr_o;
        p_data = mem_data_o;
        p_we   = mem_we_o;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_strobes"},
                    {24'd0, stall, cache_load, cache_edit, cache_store, mem_cs_o, mem_we_o, 2'b00}, 32'd0);
        checkOutput({tag, "_cache_addr"}, cache_addr, 32'd0);
        checkOutput({tag, "_cache_din"}, cache_din, 32'd0);
        checkOutput({tag, "_ubhw"}, {29'd0, cache_u_b_h_w}, 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        checkOutput({tag, "_mem_data"}, mem_data_o, 32'd0);
        checkOutput({tag, "_data_r"}, data_r, 32'd0);
    endtask

    // Drives one CPU request, holds it while stalled and records the IDLE-cycle cache strobes.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] width,
                                 output int n_stall, output logic [31:0] rd_data,
                                 output logic [31:0] idle_addr, output logic [31:0] idle_din,
                                 output logic [1:0] idle_strobe);
        logic done;
        @(negedge clk); #1;
        en_r = rd; en_w = wr; addr_rw = addr; data_w = wdata; u_b_h_w = width;
        #2;
        idle_addr   = cache_addr;
        idle_din    = cache_din;
        idle_strobe = {cache_edit, cache_load};
        n_stall = 0;
        rd_data = 32'hxxxx_xxxx;
        done    = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (stall) begin
                n_stall++;
                @(negedge clk); #3;
            end else begin
                rd_data = data_r;
                done    = 1'b1;
            end
        end
        checkOutput("request_completes", {31'd0, done}, 32'd1);
        @(negedge clk); #1;
        en_r = 1'b0; en_w = 1'b0;
    endtask

    task automatic checkMiss(input string tag, input logic [31:0] fill_base,
                             input logic [31:0] back_base, input int n_back);
        checkOutput({tag, "_rd_count"}, rd_n - rb, 32'd4);
        checkOutput({tag, "_wr_count"}, wr_n - wb, n_back);
        checkOutput({tag, "_store_count"}, st_n - sb, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_rd_addr%0d", tag, i), rd_log[rb+i], fill_base + 32'(4*i));
            checkOutput($sformatf("%s_st_addr%0d", tag, i), st_addr_log[sb+i], fill_base + 32'(4*i));
            checkOutput($sformatf("%s_st_din%0d", tag, i), st_din_log[sb+i],
                        32'hA500_0000 | (fill_base + 32'(4*i)));
            checkOutput($sformatf("%s_st_width%0d", tag, i), {29'd0, st_w_log[sb+i]}, 32'd2);
        end
        for (int i = 0; i < n_back; i++) begin
            checkOutput($sformatf("%s_wr_addr%0d", tag, i), wr_addr_log[wb+i], back_base + 32'(4*i));
            checkOutput($sformatf("%s_wr_data%0d", tag, i), wr_data_log[wb+i],
                        32'hA500_0000 | (back_base + 32'(4*i)));
        end
    endtask

    task automatic markLogs();
        rb = rd_n; wb = wr_n; sb = st_n; eb = edit_n; lb = load_n; ub = unstable_n;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; en_r = 1'b1; en_w = 1'b0; u_b_h_w = 3'b010;
        addr_rw = 32'h0000_0104; data_w = 32'h0000_1234;
        cache_valid = 1'b0; cache_dirty = 1'b0; cache_tag = 23'd0;

        // Reset held with a pending request: every output must stay low.
        repeat (3) @(negedge clk);
        #3;
        checkAllZero("reset");
        @(negedge clk); #1;
        rst = 1'b1; en_r = 1'b0;
        #2;
        checkOutput("idle_no_stall", {31'd0, stall}, 32'd0);

        $display("[TB] load hit at 0x104");
        hit_force = 1'b1;
        markLogs();
        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'd0, 3'b010, stalls, rdata, iaddr, idin, istr);
        checkOutput("hit_stalls", stalls, 32'd1);
        checkOutput("hit_data_r", rdata, 32'hD000_0104);
        checkOutput("hit_idle_strobes", {30'd0, istr}, 32'd1);
        checkOutput("hit_cache_addr", iaddr, 32'h0000_0104);
        checkOutput("hit_load_cycles", load_n - lb, 32'd1);
        checkOutput("hit_mem_requests", (rd_n - rb) + (wr_n - wb), 32'd0);

        $display("[TB] byte store 0xAB to 0x103 on hit, load also raised");
        markLogs();
        applyStimulus(1'b1, 1'b1, 32'h0000_0103, 32'h0000_00AB, 3'b000, stalls, rdata, iaddr, idin, istr);
        checkOutput("store_stalls", stalls, 32'd1);
        checkOutput("store_idle_strobes", {30'd0, istr}, 32'd2);
        checkOutput("store_cache_din", idin, 32'h0000_00AB);
        checkOutput("store_cache_addr", iaddr, 32'h0000_0103);
        checkOutput("store_edit_cycles", edit_n - eb, 32'd1);
        checkOutput("store_load_cycles", load_n - lb, 32'd0);

        $display("[TB] clean miss load 0x200");
        hit_force = 1'b0; cache_valid = 1'b0; cache_dirty = 1'b0; cache_tag = 23'h0;
        markLogs();
        st_goal = st_n + 4;
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'd0, 3'b010, stalls, rdata, iaddr, idin, istr);
        checkOutput("clean_stalls", stalls, 32'd8);
        checkOutput("clean_data_r", rdata, 32'hA500_0200);
        checkMiss("clean", 32'h0000_0200, 32'h0, 0);

        $display("[TB] dirty miss load 0x400, victim tag 0x1");
        cache_valid = 1'b1; cache_dirty = 1'b1; cache_tag = 23'h1;
        markLogs();
        st_goal = st_n + 4;
        applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'd0, 3'b010, stalls, rdata, iaddr, idin, istr);
        checkOutput("dirty_stalls", stalls, 32'd16);
        checkOutput("dirty_data_r", rdata, 32'hA500_0400);
        checkMiss("dirty", 32'h0000_0400, 32'h0000_0200, 4);

        $display("[TB] dirty miss load 0x608 with 3-cycle ack delay");
        cache_tag = 23'h2; ack_delay = 3;
        markLogs();
        st_goal = st_n + 4;
        applyStimulus(1'b1, 1'b0, 32'h0000_0608, 32'd0, 3'b010, stalls, rdata, iaddr, idin, istr);
        checkOutput("slow_stalls", stalls, 32'd40);
        checkOutput("slow_data_r", rdata, 32'hA500_0608);
        checkOutput("slow_mem_stable", unstable_n - ub, 32'd0);
        checkMiss("slow", 32'h0000_0600, 32'h0000_0400, 4);
        ack_delay = 0;

        $display("[TB] reset during refill word 2 of 0x800");
        cache_valid = 1'b0; cache_dirty = 1'b0;
        markLogs();
        st_goal = st_n + 4;
        @(negedge clk); #1;
        en_r = 1'b1; en_w = 1'b0; addr_rw = 32'h0000_0800; u_b_h_w = 3'b010;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk); #1;
            if (mem_cs_o && mem_addr_o == 32'h0000_0808) found = 1'b1;
        end
        rst = 1'b0;
        checkOutput("midfill_reached_word2", {31'd0, found}, 32'd1);
        @(negedge clk); #3;
        checkAllZero("midfill");
        checkOutput("midfill_store_count", st_n - sb, 32'd2);
        checkOutput("midfill_rd_count", rd_n - rb, 32'd2);
        @(negedge clk); #1;
        rst = 1'b1; en_r = 1'b0;
        #2;
        checkOutput("post_reset_idle", {30'd0, stall, mem_cs_o}, 32'd0);

        hit_force = 1'b1;
        markLogs();
        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'd0, 3'b010, stalls, rdata, iaddr, idin, istr);
        checkOutput("after_reset_stalls", stalls, 32'd1);
        checkOutput("after_reset_data_r", rdata, 32'hD000_0104);
        checkOutput("after_reset_mem_requests", (rd_n - rb) + (wr_n - wb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
